multimode_trigger_engine: RTL and testbench

MULTIMODE_TRIGGER_ENGINE -- requirements
Module: multimode_trigger_engine

---
 rtl/trig_pkg.sv | 34 +++
 rtl/trig_output_slot.sv | 57 +++++
 rtl/multimode_trigger_engine.sv | 159 +++++++++++++++
 tb/tb_multimode_trigger_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared types for the multimode trigger engine: edge modes, per-channel states,
// cause bits and the event payload carried by the output slot.
package trig_pkg;

  // Payload fields are sized for the largest supported configuration.
  localparam int unsigned MAX_CH_W    = 6;
  localparam int unsigned MAX_ADC_W   = 16;
  localparam int unsigned MAX_DERIV_W = MAX_ADC_W + 1;
  localparam int unsigned CAUSE_W     = 2;

  localparam int unsigned CAUSE_LEVEL_BIT = 0;
  localparam int unsigned CAUSE_DERIV_BIT = 1;

  typedef enum logic [1:0] {
    EDGE_RISING     = 2'd0,
    EDGE_FALLING    = 2'd1,
    EDGE_EITHER     = 2'd2,
    EDGE_LEVEL_HIGH = 2'd3
  } edge_mode_e;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } chan_state_e;

  typedef struct packed {
    logic [MAX_CH_W-1:0]    channel;
    logic [MAX_ADC_W-1:0]   value;
    logic [MAX_DERIV_W-1:0] deriv;
    logic [CAUSE_W-1:0]     cause;
  } trig_event_t;

endpackage

// File: rtl/trig_output_slot.sv
// Single-entry valid/ready event holding register with a saturating count of
// events that arrived while the slot was full and not draining.
module trig_output_slot
  import trig_pkg::*;
#(
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  trig_event_t           ev_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output trig_event_t           ev_o,
  output logic [DROP_WIDTH-1:0] drop_count_o
);

  logic                  valid_q, valid_d;
  trig_event_t           ev_q, ev_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;

  // A load in the handshake cycle overrides the clear, so valid stays high.
  always_comb begin
    valid_d = valid_q;
    ev_d    = ev_q;
    drop_d  = drop_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
      ev_d    = '0;
    end
    if (load_i) begin
      if (!valid_q || ready_i) begin
        valid_d = 1'b1;
        ev_d    = ev_i;
      end else if (drop_q != {DROP_WIDTH{1'b1}}) begin
        drop_d = drop_q + DROP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ev_q    <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ev_q    <= ev_d;
      drop_q  <= drop_d;
    end
  end

  assign valid_o      = valid_q;
  assign ev_o         = ev_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/multimode_trigger_engine.sv
// Per-channel level/derivative trigger engine: S1 registers the sample, S2 reads
// and updates channel history and hands any trigger to the output slot.
module multimode_trigger_engine
  import trig_pkg::*;
#(
  parameter  int unsigned NUM_CHANNELS  = 16,
  parameter  int unsigned ADC_WIDTH     = 12,
  parameter  int unsigned HOLDOFF_WIDTH = 8,
  parameter  int unsigned DROP_WIDTH    = 16,
  localparam int unsigned CH_W          = $clog2(NUM_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADC_WIDTH-1:0]     data_in,
  input  logic [CH_W-1:0]          channel_in,
  input  logic                     data_valid,
  input  logic [ADC_WIDTH-1:0]     thresh_level,
  input  logic [ADC_WIDTH-1:0]     deriv_threshold,
  input  logic [NUM_CHANNELS-1:0]  deriv_enable,
  input  logic [NUM_CHANNELS-1:0]  channel_mask,
  input  logic [1:0]               edge_mode,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_samples,
  output logic                     trigger_valid,
  input  logic                     trigger_ready,
  output logic [CH_W-1:0]          trigger_channel,
  output logic [ADC_WIDTH-1:0]     trigger_value,
  output logic [ADC_WIDTH:0]       trigger_deriv,
  output logic [1:0]               trigger_cause,
  output logic [DROP_WIDTH-1:0]    drop_count
);

  localparam int unsigned DW = ADC_WIDTH + 1;

  // S1 sample register
  logic                 s1_valid_q;
  logic [ADC_WIDTH-1:0] s1_data_q;
  logic [CH_W-1:0]      s1_ch_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_ch_q    <= '0;
    end else begin
      s1_valid_q <= data_valid;
      s1_data_q  <= data_in;
      s1_ch_q    <= channel_in;
    end
  end

  // Per-channel history
  logic [ADC_WIDTH-1:0]     prev_q  [NUM_CHANNELS];
  chan_state_e              state_q [NUM_CHANNELS];
  logic [HOLDOFF_WIDTH-1:0] hold_q  [NUM_CHANNELS];

  logic                     s2_take;
  logic [ADC_WIDTH-1:0]     cur, prev;
  chan_state_e              st, state_d;
  logic [HOLDOFF_WIDTH-1:0] hcnt, hold_d;
  logic signed [DW-1:0]     deriv;
  logic [DW-1:0]            deriv_abs;
  logic                     rise, fall, level_hit, deriv_hit, trig;
  edge_mode_e               mode;
  trig_event_t              ev;

  assign s2_take = s1_valid_q && (32'(s1_ch_q) < NUM_CHANNELS);
  assign cur     = s1_data_q;
  assign prev    = prev_q[s1_ch_q];
  assign st      = state_q[s1_ch_q];
  assign hcnt    = hold_q[s1_ch_q];
  assign mode    = edge_mode_e'(edge_mode);

  assign deriv     = $signed({1'b0, cur}) - $signed({1'b0, prev});
  assign deriv_abs = deriv[DW-1] ? DW'(-deriv) : DW'(deriv);
  assign deriv_hit = deriv_enable[s1_ch_q] && (deriv_abs >= {1'b0, deriv_threshold});
  assign rise      = (prev < thresh_level) && (cur >= thresh_level);
  assign fall      = (prev >= thresh_level) && (cur < thresh_level);

  always_comb begin
    level_hit = 1'b0;
    case (mode)
      EDGE_RISING:     level_hit = rise;
      EDGE_FALLING:    level_hit = fall;
      EDGE_EITHER:     level_hit = rise || fall;
      EDGE_LEVEL_HIGH: level_hit = (cur >= thresh_level);
      default:         level_hit = 1'b0;
    endcase
  end

  // Channel FSM; only the sampled channel advances, masked channels still count holdoff.
  always_comb begin
    state_d = st;
    hold_d  = hcnt;
    trig    = 1'b0;
    case (st)
      EMPTY: state_d = ARMED;
      ARMED: begin
        if (channel_mask[s1_ch_q] && (level_hit || deriv_hit)) begin
          trig = 1'b1;
          if (holdoff_samples != '0) begin
            state_d = HOLDOFF;
            hold_d  = holdoff_samples;
          end
        end
      end
      HOLDOFF: begin
        hold_d = hcnt - HOLDOFF_WIDTH'(1);
        if (hold_d == '0) state_d = ARMED;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        prev_q[i]  <= '0;
        state_q[i] <= EMPTY;
        hold_q[i]  <= '0;
      end
    end else if (s2_take) begin
      prev_q[s1_ch_q]  <= cur;
      state_q[s1_ch_q] <= state_d;
      hold_q[s1_ch_q]  <= hold_d;
    end
  end

  always_comb begin
    ev                        = '0;
    ev.channel                = MAX_CH_W'(s1_ch_q);
    ev.value                  = MAX_ADC_W'(cur);
    ev.deriv                  = MAX_DERIV_W'(deriv);
    ev.cause[CAUSE_LEVEL_BIT] = level_hit;
    ev.cause[CAUSE_DERIV_BIT] = deriv_hit;
  end

  trig_event_t slot_ev;
  logic        unused_slot_bits;

  trig_output_slot #(
    .DROP_WIDTH (DROP_WIDTH)
  ) u_slot (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (s2_take && trig),
    .ev_i         (ev),
    .ready_i      (trigger_ready),
    .valid_o      (trigger_valid),
    .ev_o         (slot_ev),
    .drop_count_o (drop_count)
  );

  assign trigger_channel  = slot_ev.channel[CH_W-1:0];
  assign trigger_value    = slot_ev.value[ADC_WIDTH-1:0];
  assign trigger_deriv    = slot_ev.deriv[DW-1:0];
  assign trigger_cause    = slot_ev.cause;
  assign unused_slot_bits = ^slot_ev;

endmodule

// File: tb/tb_multimode_trigger_engine.sv
// Scoreboard bench for multimode_trigger_engine: directed samples push expected
// events, a forked monitor pops and compares on every output handshake.
module tb_multimode_trigger_engine;

  localparam int NCH = 16;
  localparam int AW  = 12;
  localparam int HW  = 8;
  localparam int DW  = 16;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] data_in;
  logic [CW-1:0] channel_in;
  logic          data_valid;
  logic [AW-1:0] thresh_level;
  logic [AW-1:0] deriv_threshold;
  logic [NCH-1:0] deriv_enable;
  logic [NCH-1:0] channel_mask;
  logic [1:0]    edge_mode;
  logic [HW-1:0] holdoff_samples;
  logic          trigger_valid;
  logic          trigger_ready;
  logic [CW-1:0] trigger_channel;
  logic [AW-1:0] trigger_value;
  logic [AW:0]   trigger_deriv;
  logic [1:0]    trigger_cause;
  logic [DW-1:0] drop_count;

  always #5 clk = ~clk;

  multimode_trigger_engine #(
    .NUM_CHANNELS  (NCH),
    .ADC_WIDTH     (AW),
    .HOLDOFF_WIDTH (HW),
    .DROP_WIDTH    (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in         (data_in),
    .channel_in      (channel_in),
    .data_valid      (data_valid),
    .thresh_level    (thresh_level),
    .deriv_threshold (deriv_threshold),
    .deriv_enable    (deriv_enable),
    .channel_mask    (channel_mask),
    .edge_mode       (edge_mode),
    .holdoff_samples (holdoff_samples),
    .trigger_valid   (trigger_valid),
    .trigger_ready   (trigger_ready),
    .trigger_channel (trigger_channel),
    .trigger_value   (trigger_value),
    .trigger_deriv   (trigger_deriv),
    .trigger_cause   (trigger_cause),
    .drop_count      (drop_count)
  );

  typedef struct {
    int ch;
    int val;
    int deriv;
    int cause;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    int   a_ch, a_val, a_der, a_cause;
    forever begin
      @(negedge clk);
      if (rst_n && trigger_valid && trigger_ready) begin
        checks++;
        a_ch    = int'(trigger_channel);
        a_val   = int'(trigger_value);
        a_der   = int'($signed(trigger_deriv));
        a_cause = int'(trigger_cause);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got ch=%0d val=%0d deriv=%0d cause=%0d at cyc=%0d, none expected",
                   a_ch, a_val, a_der, a_cause, cyc);
        end else begin
          e = exp_q.pop_front();
          if (a_ch != e.ch || a_val != e.val || a_der != e.deriv || a_cause != e.cause ||
              (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL event: got ch=%0d val=%0d deriv=%0d cause=%0d cyc=%0d expected ch=%0d val=%0d deriv=%0d cause=%0d cyc=%0d",
                     a_ch, a_val, a_der, a_cause, cyc, e.ch, e.val, e.deriv, e.cause, e.cyc);
          end
        end
      end
    end
  endtask

  // Drives one sample; lat=1 also pins the event to 2 cycles after data_valid.
  task automatic send(input int ch, input int val, input bit trig, input int cause,
                      input int deriv, input bit lat);
    exp_t e;
    @(posedge clk);
    #1;
    data_valid = 1'b1;
    channel_in = CW'(ch);
    data_in    = AW'(val);
    if (trig) begin
      e = '{ch, val, deriv, cause, (lat ? cyc + 2 : -1)};
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      data_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   int'(trigger_valid),   0);
    check({tag, "_channel"}, int'(trigger_channel), 0);
    check({tag, "_value"},   int'(trigger_value),   0);
    check({tag, "_deriv"},   int'(trigger_deriv),   0);
    check({tag, "_cause"},   int'(trigger_cause),   0);
    check({tag, "_drop"},    int'(drop_count),      0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    data_in         = '0;
    channel_in      = '0;
    data_valid      = 1'b0;
    thresh_level    = 12'd2048;
    deriv_threshold = 12'd1024;
    deriv_enable    = '0;
    channel_mask    = '1;
    edge_mode       = 2'd0;
    holdoff_samples = '0;
    trigger_ready   = 1'b1;
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_outputs("reset");

    // Rising crossing on ch0
    send(0, 100, 0, 0, 0, 0);
    send(0, 1500, 0, 0, 0, 0);
    send(0, 2100, 1, 1, 600, 1);
    idle(4);

    // Derivative-only hit on ch1, then the same pattern with the enable cleared
    deriv_enable = 16'h0002;
    send(1, 500, 0, 0, 0, 0);
    send(1, 500, 0, 0, 0, 0);
    send(1, 2000, 1, 2, 1500, 1);
    idle(4);
    deriv_enable = 16'h0000;
    send(1, 500, 0, 0, 0, 0);
    send(1, 500, 0, 0, 0, 0);
    send(1, 2000, 0, 0, 0, 0);
    idle(4);

    // Level-high with holdoff 3: samples 2, 6, 10 fire
    edge_mode       = 2'd3;
    holdoff_samples = 8'd3;
    for (int i = 1; i <= 10; i++)
      send(2, 3000, (i == 2 || i == 6 || i == 10), 1, 0, 1);
    idle(4);
    holdoff_samples = 8'd0;

    // Full-scale derivative both directions on ch3
    edge_mode    = 2'd0;
    deriv_enable = 16'h0008;
    send(3, 0, 0, 0, 0, 0);
    send(3, 4095, 1, 3, 4095, 1);
    send(3, 0, 1, 2, -4095, 1);
    idle(4);
    deriv_enable = 16'h0000;

    // Back-pressure: first event held, two dropped
    edge_mode = 2'd3;
    send(4, 3000, 0, 0, 0, 0);
    send(5, 3000, 0, 0, 0, 0);
    send(6, 3000, 0, 0, 0, 0);
    idle(4);
    trigger_ready = 1'b0;
    send(4, 3000, 1, 1, 0, 0);
    send(5, 3000, 0, 0, 0, 0);
    send(6, 3000, 0, 0, 0, 0);
    idle(4);
    check("held_valid",   int'(trigger_valid),   1);
    check("held_channel", int'(trigger_channel), 4);
    check("held_value",   int'(trigger_value),   3000);
    check("drop_count",   int'(drop_count),      2);
    @(posedge clk);
    #1;
    trigger_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drained_valid", int'(trigger_valid), 0);
    check("drop_kept",     int'(drop_count),    2);
    idle(2);

    // Channel mask: only ch0..3 fire
    do_reset();
    check_reset_outputs("reset2");
    channel_mask = 16'h000F;
    for (int c = 0; c < 8; c++) send(c, 100, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) send(c, 3000, (c < 4), 1, 2900, 1);
    idle(4);

    // Reset with a trigger in flight: it must vanish
    send(0, 3000, 0, 0, 0, 0);
    do_reset();
    check_reset_outputs("reset3");
    for (int c = 0; c < 4; c++) send(c, 3000, 0, 0, 0, 0);
    idle(4);
    for (int c = 0; c < 4; c++) send(c, 3000, 1, 1, 0, 1);
    idle(6);

    check("leftover_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
